// File: rtl/shared_bram_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shared_bram_pkg
// Description : Shared types and helpers for the shared BRAM burst bridge.
//               Holds the bridge FSM state enum, the byte-address field
//               offsets and the host address decoder that splits a host
//               byte address into {is_dmem, bank, in_bank_addr}.
// Revision    : 1.0 - initial burst-capable release
// ============================================================================
package shared_bram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Byte offset inside a word occupies the low bits of every address.
  localparam int unsigned BYTE_OFF_BITS = 2;
  // Up to eight data banks, so the bank field never exceeds three bits.
  localparam int unsigned MAX_DSEL_BITS = 3;
  // Decoder input width; any legal host address fits comfortably.
  localparam int unsigned DEC_IN_W      = 64;

  typedef struct packed {
    logic                     is_dmem;
    logic [MAX_DSEL_BITS-1:0] bank;
    logic [31:0]              in_bank_addr;
  } addr_fields_t;

  // A single data bank still gets a one-bit bank field so the address
  // layout stays uniform; bank 1 then decodes as out of range.
  function automatic int unsigned dsel_bits_for(input int unsigned num_dmem);
    return (num_dmem <= 1) ? 1 : $clog2(num_dmem);
  endfunction

  // Bit position of the bank field.
  function automatic int unsigned bank_lsb(input int unsigned logsize);
    return logsize + BYTE_OFF_BITS;
  endfunction

  // Bit position of the imem/dmem space select (address MSB).
  function automatic int unsigned space_bit(input int unsigned logsize,
                                            input int unsigned dsel_bits);
    return logsize + BYTE_OFF_BITS + dsel_bits;
  endfunction

  function automatic addr_fields_t decode_addr(input logic [DEC_IN_W-1:0] addr,
                                               input int unsigned         logsize,
                                               input int unsigned         dsel_bits);
    addr_fields_t        f;
    logic [DEC_IN_W-1:0] in_mask;
    logic [DEC_IN_W-1:0] bank_mask;
    logic [DEC_IN_W-1:0] bank_raw;
    logic [DEC_IN_W-1:0] space_raw;
    in_mask        = (DEC_IN_W'(1) << bank_lsb(logsize)) - DEC_IN_W'(1);
    bank_mask      = (DEC_IN_W'(1) << dsel_bits) - DEC_IN_W'(1);
    bank_raw       = (addr >> bank_lsb(logsize)) & bank_mask;
    space_raw      = addr >> space_bit(logsize, dsel_bits);
    f.is_dmem      = |(space_raw & DEC_IN_W'(1));
    f.bank         = MAX_DSEL_BITS'(bank_raw);
    f.in_bank_addr = 32'(addr & in_mask);
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shared_bram_bridge_read_mux.sv
`default_nettype none
// ============================================================================
// Module      : bram_read_mux
// Description : Registered (NUM_DMEM+1)-way read-data select with a matching
//               valid/last pipeline. The issue-side controls arrive in the
//               same cycle as the BRAM address; they are delayed one stage to
//               line up with the 1-cycle BRAM read data, then the selected
//               word is registered onto the host read port.
// Ports       : clk, reset (sync, active-low)
//               issue_valid/last/dmem/bank/zero - per-beat read controls
//               imem_dout, dmem_dout            - BRAM read data
//               rvalid, rdata, rlast            - registered host read beat
// Revision    : 1.0 - initial burst-capable release
// ============================================================================
module bram_read_mux #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_DMEM  = 4,
  parameter int unsigned DSEL_BITS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic                      issue_last,
  input  logic                      issue_dmem,
  input  logic [DSEL_BITS-1:0]      issue_bank,
  input  logic                      issue_zero,
  input  logic [WIDTH-1:0]          imem_dout,
  input  logic [NUM_DMEM*WIDTH-1:0] dmem_dout,
  output logic                      rvalid,
  output logic [WIDTH-1:0]          rdata,
  output logic                      rlast
);

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_last_q,  s1_last_d;
  logic                 s1_dmem_q,  s1_dmem_d;
  logic [DSEL_BITS-1:0] s1_bank_q,  s1_bank_d;
  logic                 s1_zero_q,  s1_zero_d;
  logic                 rvalid_q,   rvalid_d;
  logic [WIDTH-1:0]     rdata_q,    rdata_d;
  logic                 rlast_q,    rlast_d;
  logic [WIDTH-1:0]     sel_data;

  // Select among the BRAM outputs using the stage-1 controls, which are
  // aligned with the data the BRAMs present this cycle.
  always_comb begin
    sel_data = '0;
    if (!s1_zero_q) begin
      if (!s1_dmem_q) begin
        sel_data = imem_dout;
      end else begin
        for (int b = 0; b < int'(NUM_DMEM); b++) begin
          if (s1_bank_q == DSEL_BITS'(b)) begin
            sel_data = dmem_dout[b*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  always_comb begin
    s1_valid_d = issue_valid;
    s1_last_d  = issue_valid & issue_last;
    s1_dmem_d  = issue_dmem;
    s1_bank_d  = issue_bank;
    s1_zero_d  = issue_zero;
    rvalid_d   = s1_valid_q;
    rlast_d    = s1_valid_q & s1_last_q;
    rdata_d    = s1_valid_q ? sel_data : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_dmem_q  <= 1'b0;
      s1_bank_q  <= '0;
      s1_zero_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rlast_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_dmem_q  <= s1_dmem_d;
      s1_bank_q  <= s1_bank_d;
      s1_zero_q  <= s1_zero_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rlast_q    <= rlast_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rlast  = rlast_q;

endmodule
`default_nettype wire

// File: rtl/shared_bram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : shared_bram_bridge
// Description : Host-side burst bridge onto the instruction BRAM and
//               NUM_DMEM data BRAM banks through one shared address/data
//               port. Incrementing bursts with a req/ready handshake,
//               registered read data with last-beat flag, out-of-range bank
//               error reporting and a cpu_halt during imem writes.
// Ports       : clk, reset (sync, active-low)
//               host_req/ready/we/addr/len/wdata/wstrb - command + write beats
//               host_rvalid/rdata/rlast/err             - read beats, status
//               bram_addr/din, imem_wr_en, dmem_wr_en   - shared BRAM port
//               imem_dout, dmem_dout                    - BRAM read data
//               cpu_halt                                - core stall request
// Revision    : 1.0 - initial burst-capable release
// ============================================================================
module shared_bram_bridge
  import shared_bram_pkg::*;
#(
  parameter  int unsigned WIDTH        = 32,
  parameter  int unsigned SIZE         = 1024,
  parameter  int unsigned NUM_COL      = 4,
  parameter  int unsigned NUM_DMEM     = 4,
  parameter  int unsigned MAX_LEN_BITS = 8,
  localparam int unsigned LOGSIZE      = $clog2(SIZE),
  localparam int unsigned DSEL_BITS    = dsel_bits_for(NUM_DMEM),
  localparam int unsigned ADDR_W       = LOGSIZE + 2 + DSEL_BITS + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         host_req,
  output logic                         host_ready,
  input  logic                         host_we,
  input  logic [ADDR_W-1:0]            host_addr,
  input  logic [MAX_LEN_BITS-1:0]      host_len,
  input  logic [WIDTH-1:0]             host_wdata,
  input  logic [NUM_COL-1:0]           host_wstrb,
  output logic                         host_rvalid,
  output logic [WIDTH-1:0]             host_rdata,
  output logic                         host_rlast,
  output logic                         host_err,
  output logic [LOGSIZE+1:0]           bram_addr,
  output logic [WIDTH-1:0]             bram_din,
  output logic [NUM_COL-1:0]           imem_wr_en,
  output logic [NUM_DMEM*NUM_COL-1:0]  dmem_wr_en,
  input  logic [WIDTH-1:0]             imem_dout,
  input  logic [NUM_DMEM*WIDTH-1:0]    dmem_dout,
  output logic                         cpu_halt
);

  localparam int unsigned BA_W = LOGSIZE + BYTE_OFF_BITS;
  localparam int unsigned WE_W = NUM_DMEM * NUM_COL;

  state_e                  state_q, state_d;
  logic [MAX_LEN_BITS-1:0] len_q, len_d;
  logic [MAX_LEN_BITS-1:0] cnt_q, cnt_d;
  logic [BA_W-1:0]         addr_q, addr_d;
  logic                    tgt_dmem_q, tgt_dmem_d;
  logic [DSEL_BITS-1:0]    tgt_bank_q, tgt_bank_d;
  logic                    err_q, err_d;
  logic                    halt_q, halt_d;
  logic [BA_W-1:0]         bram_addr_q, bram_addr_d;
  logic [WIDTH-1:0]        bram_din_q, bram_din_d;
  logic [NUM_COL-1:0]      imem_we_q, imem_we_d;
  logic [WE_W-1:0]         dmem_we_q, dmem_we_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_last_q, rd_last_d;
  logic                    rd_dmem_q, rd_dmem_d;
  logic [DSEL_BITS-1:0]    rd_bank_q, rd_bank_d;
  logic                    rd_zero_q, rd_zero_d;

  addr_fields_t            dec;
  logic [BA_W-1:0]         dec_in_bank;
  logic [DSEL_BITS-1:0]    dec_bank;
  logic                    dec_bad;

  logic                    is_idle;
  logic                    accept;
  logic                    wbeat;
  logic                    last_cnt;
  logic                    beat_dmem;
  logic [DSEL_BITS-1:0]    beat_bank;
  logic                    beat_bad;
  logic [BA_W-1:0]         beat_addr;

  assign dec         = decode_addr(DEC_IN_W'(host_addr), LOGSIZE, DSEL_BITS);
  assign dec_in_bank = BA_W'(dec.in_bank_addr);
  assign dec_bank    = DSEL_BITS'(dec.bank);
  // The full 3-bit decoded bank is compared so a non-power-of-two bank count
  // flags the unused encodings.
  assign dec_bad     = dec.is_dmem && (32'(dec.bank) >= NUM_DMEM);

  assign is_idle  = (state_q == IDLE);
  assign accept   = is_idle && host_req;
  assign wbeat    = host_req && ((is_idle && host_we) || (state_q == WRITE));
  assign last_cnt = (cnt_q == len_q);

  // The command cycle carries beat 0, so its target comes straight from the
  // decoder; later beats use the latched target.
  assign beat_dmem = is_idle ? dec.is_dmem : tgt_dmem_q;
  assign beat_bank = is_idle ? dec_bank    : tgt_bank_q;
  assign beat_bad  = is_idle ? dec_bad     : err_q;
  assign beat_addr = is_idle ? dec_in_bank : addr_q;

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (host_req) begin
          if (!host_we) begin
            state_d = READ;
          end else if (host_len != '0) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (host_req && last_cnt) state_d = IDLE;
      end
      READ: begin
        if (last_cnt) state_d = DRAIN;
      end
      DRAIN: begin
        if (cnt_q == MAX_LEN_BITS'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  // Gated by reset so the handshake reads 0 while reset is held.
  always_comb begin
    host_ready = 1'b0;
    if (reset && (state_q == IDLE || state_q == WRITE)) host_ready = 1'b1;
  end

  // ---------------------------------------------------------------- datapath next values
  always_comb begin
    len_d       = len_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    tgt_dmem_d  = tgt_dmem_q;
    tgt_bank_d  = tgt_bank_q;
    err_d       = err_q;
    halt_d      = halt_q;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    imem_we_d   = '0;
    dmem_we_d   = '0;
    rd_valid_d  = 1'b0;
    rd_last_d   = 1'b0;
    rd_dmem_d   = rd_dmem_q;
    rd_bank_d   = rd_bank_q;
    rd_zero_d   = rd_zero_q;

    if (accept) begin
      len_d      = host_len;
      tgt_dmem_d = dec.is_dmem;
      tgt_bank_d = dec_bank;
      err_d      = dec_bad;
      // Writes consume beat 0 now; reads issue beat 0 from the next cycle.
      addr_d     = host_we ? dec_in_bank + BA_W'(4) : dec_in_bank;
      cnt_d      = host_we ? MAX_LEN_BITS'(1) : '0;
    end

    if (wbeat) begin
      bram_addr_d = beat_addr;
      bram_din_d  = host_wdata;
      if (!beat_bad) begin
        if (!beat_dmem) begin
          imem_we_d = host_wstrb;
        end else begin
          for (int b = 0; b < int'(NUM_DMEM); b++) begin
            if (beat_bank == DSEL_BITS'(b)) dmem_we_d[b*NUM_COL +: NUM_COL] = host_wstrb;
          end
        end
      end
    end

    case (state_q)
      WRITE: begin
        if (host_req) begin
          addr_d = addr_q + BA_W'(4);
          cnt_d  = cnt_q + MAX_LEN_BITS'(1);
        end
      end
      READ: begin
        bram_addr_d = addr_q;
        addr_d      = addr_q + BA_W'(4);
        cnt_d       = last_cnt ? '0 : cnt_q + MAX_LEN_BITS'(1);
        rd_valid_d  = 1'b1;
        rd_last_d   = last_cnt;
        rd_dmem_d   = tgt_dmem_q;
        rd_bank_d   = tgt_bank_q;
        rd_zero_d   = err_q;
      end
      DRAIN: begin
        cnt_d = cnt_q + MAX_LEN_BITS'(1);
      end
      default: ;
    endcase

    // Halt rises with an imem write command and falls one cycle after the
    // FSM is back in IDLE, by which time the last write beat has landed.
    if (is_idle) halt_d = accept && host_we && !dec.is_dmem;
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      len_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      tgt_dmem_q  <= 1'b0;
      tgt_bank_q  <= '0;
      err_q       <= 1'b0;
      halt_q      <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      imem_we_q   <= '0;
      dmem_we_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_dmem_q   <= 1'b0;
      rd_bank_q   <= '0;
      rd_zero_q   <= 1'b0;
    end else begin
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      tgt_dmem_q  <= tgt_dmem_d;
      tgt_bank_q  <= tgt_bank_d;
      err_q       <= err_d;
      halt_q      <= halt_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      imem_we_q   <= imem_we_d;
      dmem_we_q   <= dmem_we_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_dmem_q   <= rd_dmem_d;
      rd_bank_q   <= rd_bank_d;
      rd_zero_q   <= rd_zero_d;
    end
  end

  bram_read_mux #(
    .WIDTH     (WIDTH),
    .NUM_DMEM  (NUM_DMEM),
    .DSEL_BITS (DSEL_BITS)
  ) u_read_mux (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (rd_valid_q),
    .issue_last  (rd_last_q),
    .issue_dmem  (rd_dmem_q),
    .issue_bank  (rd_bank_q),
    .issue_zero  (rd_zero_q),
    .imem_dout   (imem_dout),
    .dmem_dout   (dmem_dout),
    .rvalid      (host_rvalid),
    .rdata       (host_rdata),
    .rlast       (host_rlast)
  );

  assign host_err   = err_q;
  assign bram_addr  = bram_addr_q;
  assign bram_din   = bram_din_q;
  assign imem_wr_en = imem_we_q;
  assign dmem_wr_en = dmem_we_q;
  assign cpu_halt   = halt_q;

endmodule
`default_nettype wire

// File: tb/tb_shared_bram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_bram_bridge
// Description : Directed self-checking bench for shared_bram_bridge with
//               three data banks, so bank index 3 is out of range.
// Revision    : 1.0
// ============================================================================
module tb_shared_bram_bridge;

  localparam int unsigned WIDTH        = 32;
  localparam int unsigned SIZE         = 1024;
  localparam int unsigned NUM_COL      = 4;
  localparam int unsigned NUM_DMEM     = 3;
  localparam int unsigned MAX_LEN_BITS = 8;
  localparam int unsigned BA_W         = 12;
  localparam int unsigned ADDR_W       = 15;

  logic                         clk = 1'b0;
  logic                         reset = 1'b0;
  logic                         host_req = 1'b0;
  logic                         host_ready;
  logic                         host_we = 1'b0;
  logic [ADDR_W-1:0]            host_addr = '0;
  logic [MAX_LEN_BITS-1:0]      host_len = '0;
  logic [WIDTH-1:0]             host_wdata = '0;
  logic [NUM_COL-1:0]           host_wstrb = '0;
  logic                         host_rvalid;
  logic [WIDTH-1:0]             host_rdata;
  logic                         host_rlast;
  logic                         host_err;
  logic [BA_W-1:0]              bram_addr;
  logic [WIDTH-1:0]             bram_din;
  logic [NUM_COL-1:0]           imem_wr_en;
  logic [NUM_DMEM*NUM_COL-1:0]  dmem_wr_en;
  logic [WIDTH-1:0]             imem_dout = '0;
  logic [NUM_DMEM*WIDTH-1:0]    dmem_dout = '0;
  logic                         cpu_halt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shared_bram_bridge #(
    .WIDTH        (WIDTH),
    .SIZE         (SIZE),
    .NUM_COL      (NUM_COL),
    .NUM_DMEM     (NUM_DMEM),
    .MAX_LEN_BITS (MAX_LEN_BITS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .host_req    (host_req),
    .host_ready  (host_ready),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_len    (host_len),
    .host_wdata  (host_wdata),
    .host_wstrb  (host_wstrb),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .host_rlast  (host_rlast),
    .host_err    (host_err),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .imem_wr_en  (imem_wr_en),
    .dmem_wr_en  (dmem_wr_en),
    .imem_dout   (imem_dout),
    .dmem_dout   (dmem_dout),
    .cpu_halt    (cpu_halt)
  );

  // BRAM model: 1-cycle read latency, data derived from the address.
  // imem -> 0xC000_0000 | addr, dmem bank b -> 0xB000_0000 | b<<24 | addr.
  always @(posedge clk) begin
    imem_dout <= 32'hC000_0000 | 32'(bram_addr);
    for (int b = 0; b < int'(NUM_DMEM); b++) begin
      dmem_dout[b*WIDTH +: WIDTH] <= 32'hB000_0000 | (32'(b) << 24) | 32'(bram_addr);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_ctl"}, {host_ready, host_rvalid, host_rlast, host_err, cpu_halt}, 0);
    check_eq({tag, "_rdata"}, host_rdata, 0);
    check_eq({tag, "_baddr"}, bram_addr, 0);
    check_eq({tag, "_bdin"}, bram_din, 0);
    check_eq({tag, "_wren"}, {imem_wr_en, dmem_wr_en}, 0);
  endtask

  task automatic cmd(input logic we, input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                     input logic [31:0] wdata, input logic [3:0] wstrb);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = addr;
    host_len   = len;
    host_wdata = wdata;
    host_wstrb = wstrb;
  endtask

  logic        gap_req  [7];
  logic [11:0] gap_addr [7];
  int          wr_count;

  initial begin
    // ---------------- power-on reset
    step();
    step();
    check_reset_outs("por");
    reset = 1'b1;
    step();
    check_eq("idle_ready", host_ready, 1);

    // ---------------- imem write, addr 0, len 3
    for (int k = 0; k < 4; k++) begin
      cmd(1'b1, 15'h0000, 8'd3, 32'hA0 + 32'(k), 4'hF);
      step();
      check_eq("imw_wren", imem_wr_en, 4'hF);
      check_eq("imw_addr", bram_addr, 12'(4 * k));
      check_eq("imw_din", bram_din, 32'hA0 + 32'(k));
      check_eq("imw_halt", cpu_halt, 1);
      check_eq("imw_dwren", dmem_wr_en, 0);
    end
    host_req = 1'b0;
    step();
    check_eq("imw_wren_end", imem_wr_en, 0);
    check_eq("imw_halt_end", cpu_halt, 0);
    check_eq("imw_ready_end", host_ready, 1);

    // ---------------- dmem bank 2 read, in-bank 0x100, len 2
    cmd(1'b0, 15'h6100, 8'd2, 32'h0, 4'h0);
    step();
    host_req = 1'b0;
    check_eq("rd_ready_cmd", host_ready, 0);
    check_eq("rd_err", host_err, 0);
    for (int i = 1; i <= 6; i++) begin
      step();
      check_eq("rd_valid", host_rvalid, (i >= 3 && i <= 5) ? 1 : 0);
      if (i >= 3 && i <= 5) check_eq("rd_data", host_rdata, 32'hB200_0100 + 32'(4 * (i - 3)));
      check_eq("rd_last", host_rlast, (i == 5) ? 1 : 0);
      check_eq("rd_dwren", dmem_wr_en, 0);
      check_eq("rd_halt", cpu_halt, 0);
      check_eq("rd_ready", host_ready, (i >= 5) ? 1 : 0);
    end

    // ---------------- dmem bank 1 write at 0xFFC, len 1, wraps to 0x000
    cmd(1'b1, 15'h5FFC, 8'd1, 32'h1111_1111, 4'h3);
    step();
    check_eq("wrap_dwren0", dmem_wr_en, 12'h030);
    check_eq("wrap_addr0", bram_addr, 12'hFFC);
    check_eq("wrap_iwren0", imem_wr_en, 0);
    check_eq("wrap_halt", cpu_halt, 0);
    host_wdata = 32'h2222_2222;
    step();
    check_eq("wrap_dwren1", dmem_wr_en, 12'h030);
    check_eq("wrap_addr1", bram_addr, 12'h000);
    check_eq("wrap_din1", bram_din, 32'h2222_2222);
    host_req = 1'b0;
    step();
    check_eq("wrap_dwren_end", dmem_wr_en, 0);
    check_eq("wrap_ready_end", host_ready, 1);

    // ---------------- out-of-range bank 3 read, len 1
    cmd(1'b0, 15'h7010, 8'd1, 32'h0, 4'h0);
    step();
    host_req = 1'b0;
    check_eq("err_rd_flag", host_err, 1);
    for (int i = 1; i <= 5; i++) begin
      step();
      check_eq("err_rd_valid", host_rvalid, (i == 3 || i == 4) ? 1 : 0);
      if (i == 3 || i == 4) check_eq("err_rd_data", host_rdata, 0);
      check_eq("err_rd_last", host_rlast, (i == 4) ? 1 : 0);
      check_eq("err_rd_hold", host_err, 1);
    end
    check_eq("err_rd_ready", host_ready, 1);

    // ---------------- out-of-range bank 3 write, len 1
    cmd(1'b1, 15'h7010, 8'd1, 32'h3333_3333, 4'hF);
    step();
    check_eq("err_wr_flag", host_err, 1);
    check_eq("err_wr_wren0", {imem_wr_en, dmem_wr_en}, 0);
    step();
    check_eq("err_wr_wren1", {imem_wr_en, dmem_wr_en}, 0);
    host_req = 1'b0;
    step();
    check_eq("err_wr_ready", host_ready, 1);
    check_eq("err_wr_hold", host_err, 1);

    // ---------------- valid imem read, len 0, clears host_err
    cmd(1'b0, 15'h0020, 8'd0, 32'h0, 4'h0);
    step();
    host_req = 1'b0;
    check_eq("clr_err", host_err, 0);
    check_eq("clr_halt", cpu_halt, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq("im_rd_valid", host_rvalid, (i == 3) ? 1 : 0);
      if (i == 3) check_eq("im_rd_data", host_rdata, 32'hC000_0020);
      check_eq("im_rd_last", host_rlast, (i == 3) ? 1 : 0);
    end
    check_eq("im_rd_ready", host_ready, 1);

    // ---------------- dmem bank 0 write, len 3, two-cycle gap mid-burst
    gap_req  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    gap_addr = '{12'h040, 12'h044, 12'h000, 12'h000, 12'h048, 12'h04C, 12'h000};
    wr_count = 0;
    cmd(1'b1, 15'h4040, 8'd3, 32'h0, 4'hF);
    for (int i = 0; i < 7; i++) begin
      host_req   = gap_req[i];
      host_wdata = 32'h5000 + 32'(i);
      step();
      if (dmem_wr_en != 0) wr_count++;
      check_eq("gap_wren", dmem_wr_en, gap_req[i] ? 12'h00F : 12'h000);
      if (gap_req[i]) check_eq("gap_addr", bram_addr, gap_addr[i]);
    end
    check_eq("gap_count", wr_count, 4);

    // ---------------- reset during beat 2 of a len 5 dmem write
    cmd(1'b1, 15'h4000, 8'd5, 32'h7777_0000, 4'hF);
    step();
    host_wdata = 32'h7777_0001;
    step();
    host_wdata = 32'h7777_0002;
    reset = 1'b0;
    step();
    check_reset_outs("midrst");
    reset    = 1'b1;
    host_req = 1'b0;
    step();
    check_eq("midrst_wren", {imem_wr_en, dmem_wr_en}, 0);
    check_eq("midrst_ready", host_ready, 1);
    // A read command only drops ready if the FSM really restarted in IDLE.
    cmd(1'b0, 15'h0000, 8'd0, 32'h0, 4'h0);
    step();
    host_req = 1'b0;
    check_eq("midrst_idle", host_ready, 0);
    for (int i = 0; i < 4; i++) step();
    check_eq("final_ready", host_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
